vga_frame_analyzer: RTL

Receive-side counterpart to the TinyVGA pattern generators. The block samples the packed TinyVGA PMOD byte (hsync, vsync, 2-bit R/G/B), recovers pixel coordinates from the sync edges, and checks line length. Once per frame it reports the bounding box and count of lit pixels. It is used as an on-chip or testbench monitor that checks what a generator actually draws, for example a square at a known position.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_sync_tracker.sv | 71 +++++++
 rtl/vga_frame_analyzer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared TinyVGA timing defaults, PMOD bit positions, FSM states and frame statistics type.
// Latency: n/a. Backpressure: n/a.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_BACK_DEF   = 48;
  localparam int H_TOTAL_DEF  = 800;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_BACK_DEF   = 33;

  // vga_in = {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}
  localparam int         HSYNC_BIT = 7;
  localparam int         VSYNC_BIT = 3;
  localparam logic [7:0] RGB_MASK  = 8'h77;
  localparam logic [7:0] VGA_IDLE  = 8'h88;

  localparam logic [9:0]  CNT_MAX = 10'h3FF;
  localparam logic [18:0] LIT_MAX = 19'h7FFFF;

  typedef enum logic [1:0] {HUNT, ARM, LOCKED} state_t;

  typedef struct packed {
    logic [9:0]  min_x;
    logic [9:0]  max_x;
    logic [9:0]  min_y;
    logic [9:0]  max_y;
    logic [18:0] count;
  } frame_stats_t;

  localparam frame_stats_t STATS_CLEAR = '{
    min_x: CNT_MAX, max_x: 10'd0, min_y: CNT_MAX, max_y: 10'd0, count: 19'd0
  };

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers vga_in once, recovers sync edges and pixel coordinates; lit/x/y describe the registered pixel.
// Latency: 1 cycle from vga_in to lit/x/y. Backpressure: none, free-running monitor.
module vga_sync_tracker
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_in,
  output logic       hs_rise,
  output logic       vs_rise,
  output logic       lit,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] hcnt_last
);

  localparam logic [9:0] H_LO = 10'(H_BACK);
  localparam logic [9:0] H_HI = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0] V_LO = 10'(V_BACK);
  localparam logic [9:0] V_HI = 10'(V_BACK + V_ACTIVE);

  logic [7:0] s_q;
  logic       hs_prev_q;
  logic       vs_prev_q;
  logic [9:0] hcnt_q;
  logic [9:0] vcnt_q;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       active;

  // Idle reset value keeps the first sample after reset from looking like a sync edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= VGA_IDLE;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      hcnt_q    <= CNT_MAX;
      vcnt_q    <= CNT_MAX;
    end else begin
      s_q       <= vga_in;
      hs_prev_q <= s_q[HSYNC_BIT];
      vs_prev_q <= s_q[VSYNC_BIT];
      hcnt_q    <= hcnt;
      vcnt_q    <= vcnt;
    end
  end

  always_comb begin
    hs_rise = s_q[HSYNC_BIT] & ~hs_prev_q;
    vs_rise = s_q[VSYNC_BIT] & ~vs_prev_q;
    hcnt    = hs_rise ? 10'd0 : sat_inc(hcnt_q);
    vcnt    = vcnt_q;
    if (vs_rise) begin
      vcnt = 10'd0;
    end else if (hs_rise) begin
      vcnt = sat_inc(vcnt_q);
    end
    active = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
    lit    = active && (|(s_q & RGB_MASK));
    x      = hcnt - H_LO;
    y      = vcnt - V_LO;
  end

  assign hcnt_last = hcnt_q;

endmodule

// File: rtl/vga_frame_analyzer.sv
// Locks onto TinyVGA timing, checks line length and reports per-frame lit-pixel bounding box and count.
// Latency: frame_valid 2 cycles after the vsync rise on vga_in. Backpressure: none, results hold until next report.
module vga_frame_analyzer
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic        sync_err,
  output logic        frame_valid,
  output logic        found,
  output logic [9:0]  min_x,
  output logic [9:0]  max_x,
  output logic [9:0]  min_y,
  output logic [9:0]  max_y,
  output logic [18:0] lit_count
);

  // hcnt_last holds the count of the final pixel of the line, i.e. period - 1.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);

  logic         hs_rise;
  logic         vs_rise;
  logic         lit;
  logic [9:0]   px;
  logic [9:0]   py;
  logic [9:0]   hcnt_last;
  logic         len_bad;
  state_t       state_q;
  logic         hs_chk_q;
  frame_stats_t acc_q;
  frame_stats_t res_q;

  vga_sync_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_BACK   (V_BACK)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_in    (vga_in),
    .hs_rise   (hs_rise),
    .vs_rise   (vs_rise),
    .lit       (lit),
    .x         (px),
    .y         (py),
    .hcnt_last (hcnt_last)
  );

  assign len_bad = hs_rise && hs_chk_q && (hcnt_last != H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      hs_chk_q    <= 1'b0;
      acc_q       <= STATS_CLEAR;
      res_q       <= STATS_CLEAR;
      found       <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      sync_err    <= 1'b0;
      frame_valid <= 1'b0;
      if (lit) begin
        if (px < acc_q.min_x) acc_q.min_x <= px;
        if (px > acc_q.max_x) acc_q.max_x <= px;
        if (py < acc_q.min_y) acc_q.min_y <= py;
        if (py > acc_q.max_y) acc_q.max_y <= py;
        if (acc_q.count != LIT_MAX) acc_q.count <= acc_q.count + 19'd1;
      end
      if (hs_rise) hs_chk_q <= 1'b1;
      case (state_q)
        HUNT: begin
          acc_q    <= STATS_CLEAR;
          hs_chk_q <= 1'b0;
          if (vs_rise) state_q <= ARM;
        end
        ARM: begin
          if (len_bad) begin
            sync_err <= 1'b1;
            state_q  <= HUNT;
          end else if (vs_rise) begin
            state_q <= LOCKED;
            locked  <= 1'b1;
            acc_q   <= STATS_CLEAR;
          end
        end
        LOCKED: begin
          if (len_bad) begin
            sync_err <= 1'b1;
            locked   <= 1'b0;
            state_q  <= HUNT;
          end else if (vs_rise) begin
            res_q       <= acc_q;
            found       <= (acc_q.count != 19'd0);
            frame_valid <= 1'b1;
            acc_q       <= STATS_CLEAR;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign min_x     = res_q.min_x;
  assign max_x     = res_q.max_x;
  assign min_y     = res_q.min_y;
  assign max_y     = res_q.max_y;
  assign lit_count = res_q.count;

endmodule
